// File: rtl/finder_run_scanner.sv
// Scans a cleaned row one bit per clock and reports every dark/light run group
// matching the QR finder ratio 1:1:3:1:1. Optional FINDER_HIT_COUNT_EN adds a per-row hit counter.
module finder_run_scanner #(
  parameter int WIDTH     = 480,
  parameter int RUN_W     = $clog2(WIDTH + 1),
  parameter int MIN_TOTAL = 7
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] clean_pattern,
  input  logic             data_valid,
  output logic             hit_valid,
  output logic [RUN_W-1:0] hit_center,
  output logic [RUN_W-1:0] hit_span,
  output logic             scan_done,
`ifdef FINDER_HIT_COUNT_EN
  output logic             busy,
  output logic [7:0]       hit_count
`else
  output logic             busy
`endif
);

  localparam int PW = RUN_W + 4;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   row_q, row_d;
  logic [RUN_W-1:0]   idx_q, idx_d;
  logic [RUN_W-1:0]   curLen_q, curLen_d;
  logic               prevBit_q, prevBit_d;
  logic [RUN_W-1:0]   hist1_q, hist2_q, hist3_q, hist4_q;
  logic [RUN_W-1:0]   hist1_d, hist2_d, hist3_d, hist4_d;
  logic [2:0]         runsSeen_q, runsSeen_d;
  logic               hitValid_q, hitValid_d;
  logic [RUN_W-1:0]   hitCenter_q, hitCenter_d;
  logic [RUN_W-1:0]   hitSpan_q, hitSpan_d;
  logic               scanDone_q, scanDone_d;
`ifdef FINDER_HIT_COUNT_EN
  logic [7:0]         hitCount_q, hitCount_d;
`endif

  logic               closeRun;
  logic               accept;
  logic [2:0]         seenNext;
  logic [PW-1:0]      total;
  logic [PW-1:0]      m1, m2, m3, m4, m5;
  logic [RUN_W-1:0]   centerCalc;

  function automatic logic [PW-1:0] times14(input logic [RUN_W-1:0] r);
    return PW'(r) * PW'(14);
  endfunction

  function automatic logic outerOk(input logic [PW-1:0] m, input logic [PW-1:0] t);
    return (t <= m) && (m <= t * PW'(3));
  endfunction

  // The candidate group is the four stored runs plus the run being closed now.
  // In FLUSH idx_q has already advanced to WIDTH, the virtual closing column.
  assign closeRun   = (state_q == FLUSH) ||
                      ((state_q == SCAN) && (idx_q != '0) && (row_q[0] != prevBit_q));
  assign seenNext   = (runsSeen_q == 3'd5) ? 3'd5 : runsSeen_q + 3'd1;
  assign total      = PW'(hist1_q) + PW'(hist2_q) + PW'(hist3_q) + PW'(hist4_q) + PW'(curLen_q);
  assign m1         = times14(hist1_q);
  assign m2         = times14(hist2_q);
  assign m3         = times14(hist3_q);
  assign m4         = times14(hist4_q);
  assign m5         = times14(curLen_q);
  assign centerCalc = idx_q - curLen_q - hist4_q - hist3_q + (hist3_q >> 1);
  assign accept     = closeRun && (seenNext == 3'd5) && !prevBit_q &&
                      (total >= PW'(MIN_TOTAL)) &&
                      outerOk(m1, total) && outerOk(m2, total) &&
                      outerOk(m4, total) && outerOk(m5, total) &&
                      (total * PW'(5) <= m3) && (m3 <= total * PW'(7));

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    idx_d       = idx_q;
    curLen_d    = curLen_q;
    prevBit_d   = prevBit_q;
    hist1_d     = hist1_q;
    hist2_d     = hist2_q;
    hist3_d     = hist3_q;
    hist4_d     = hist4_q;
    runsSeen_d  = runsSeen_q;
    hitValid_d  = accept;
    hitCenter_d = accept ? centerCalc : hitCenter_q;
    hitSpan_d   = accept ? RUN_W'(total) : hitSpan_q;
    scanDone_d  = 1'b0;
`ifdef FINDER_HIT_COUNT_EN
    hitCount_d  = (accept && hitCount_q != 8'hFF) ? hitCount_q + 8'd1 : hitCount_q;
`endif

    if (closeRun) begin
      hist1_d    = hist2_q;
      hist2_d    = hist3_q;
      hist3_d    = hist4_q;
      hist4_d    = curLen_q;
      runsSeen_d = seenNext;
      curLen_d   = RUN_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (data_valid) begin
          row_d      = clean_pattern;
          idx_d      = '0;
          curLen_d   = '0;
          prevBit_d  = 1'b0;
          hist1_d    = '0;
          hist2_d    = '0;
          hist3_d    = '0;
          hist4_d    = '0;
          runsSeen_d = '0;
          state_d    = SCAN;
`ifdef FINDER_HIT_COUNT_EN
          hitCount_d = '0;
`endif
        end
      end
      SCAN: begin
        row_d     = row_q >> 1;
        idx_d     = idx_q + RUN_W'(1);
        prevBit_d = row_q[0];
        if (!closeRun) curLen_d = curLen_q + RUN_W'(1);
        if (idx_q == RUN_W'(WIDTH - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        state_d    = IDLE;
        scanDone_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      row_q       <= '0;
      idx_q       <= '0;
      curLen_q    <= '0;
      prevBit_q   <= 1'b0;
      hist1_q     <= '0;
      hist2_q     <= '0;
      hist3_q     <= '0;
      hist4_q     <= '0;
      runsSeen_q  <= '0;
      hitValid_q  <= 1'b0;
      hitCenter_q <= '0;
      hitSpan_q   <= '0;
      scanDone_q  <= 1'b0;
`ifdef FINDER_HIT_COUNT_EN
      hitCount_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      curLen_q    <= curLen_d;
      prevBit_q   <= prevBit_d;
      hist1_q     <= hist1_d;
      hist2_q     <= hist2_d;
      hist3_q     <= hist3_d;
      hist4_q     <= hist4_d;
      runsSeen_q  <= runsSeen_d;
      hitValid_q  <= hitValid_d;
      hitCenter_q <= hitCenter_d;
      hitSpan_q   <= hitSpan_d;
      scanDone_q  <= scanDone_d;
`ifdef FINDER_HIT_COUNT_EN
      hitCount_q  <= hitCount_d;
`endif
    end
  end

  assign hit_valid  = hitValid_q;
  assign hit_center = hitCenter_q;
  assign hit_span   = hitSpan_q;
  assign scan_done  = scanDone_q;
  assign busy       = (state_q != IDLE);
`ifdef FINDER_HIT_COUNT_EN
  assign hit_count  = hitCount_q;
`endif

endmodule

// File: tb/tb_finder_run_scanner.sv
// Bench for finder_run_scanner: table of rows with hand-derived hits, a hit
// scoreboard queue, plus reset-abort and busy-restart sequences.
module tb_finder_run_scanner;

  localparam int W  = 480;
  localparam int RW = 9;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [W-1:0]  clean_pattern;
  logic          data_valid;
  logic          hit_valid, scan_done, busy;
  logic [RW-1:0] hit_center, hit_span;
  logic          hit_valid8, scan_done8, busy8;
  logic [RW-1:0] hit_center8, hit_span8;
`ifdef FINDER_HIT_COUNT_EN
  logic [7:0]    hit_count, hit_count8;
`endif

  always #5 clk_in = ~clk_in;

  finder_run_scanner #(.WIDTH(W), .MIN_TOTAL(7)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .clean_pattern(clean_pattern),
    .data_valid(data_valid), .hit_valid(hit_valid), .hit_center(hit_center),
    .hit_span(hit_span), .scan_done(scan_done), .busy(busy)
`ifdef FINDER_HIT_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  // Same row stream into a copy with a stricter minimum span.
  finder_run_scanner #(.WIDTH(W), .MIN_TOTAL(8)) dut8 (
    .clk_in(clk_in), .rst_in(rst_in), .clean_pattern(clean_pattern),
    .data_valid(data_valid), .hit_valid(hit_valid8), .hit_center(hit_center8),
    .hit_span(hit_span8), .scan_done(scan_done8), .busy(busy8)
`ifdef FINDER_HIT_COUNT_EN
    , .hit_count(hit_count8)
`endif
  );

  typedef struct {
    int edgeIdx;
    int center;
    int span;
  } hit_t;

  typedef struct {
    string        name;
    logic [W-1:0] row;
    int           nHits;
    int           e0, c0, s0;
    int           e1, c1, s1;
    int           n8;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];
  hit_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   doneEdge;
  int   hits8;

  function automatic logic [W-1:0] darkAt(input logic [W-1:0] base, input int lo, input int hi);
    logic [W-1:0] r;
    r = base;
    for (int i = lo; i <= hi; i++) r[i] = 1'b0;
    return r;
  endfunction

  function automatic vec_t mkVec(input string nm, input logic [W-1:0] row, input int nHits,
                                 input int e0, input int c0, input int s0,
                                 input int e1, input int c1, input int s1, input int n8);
    vec_t v;
    v.name = nm; v.row = row; v.nHits = nHits;
    v.e0 = e0; v.c0 = c0; v.s0 = s0;
    v.e1 = e1; v.c1 = c1; v.s1 = s1;
    v.n8 = n8;
    return v;
  endfunction

  task automatic expectEq(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Push the row's expected hits, then present the row for one start edge.
  task automatic applyStimulus(input logic [W-1:0] row, input int nHits,
                               input int e0, input int c0, input int s0,
                               input int e1, input int c1, input int s1);
    hit_t h;
    if (nHits > 0) begin h.edgeIdx = e0; h.center = c0; h.span = s0; expQ.push_back(h); end
    if (nHits > 1) begin h.edgeIdx = e1; h.center = c1; h.span = s1; expQ.push_back(h); end
    doneEdge = -1;
    hits8    = 0;
    @(negedge clk_in);
    clean_pattern = row;
    data_valid    = 1'b1;
  endtask

  // Sampled 1 time unit after edge e (edge 0 is the start edge).
  task automatic checkOutput(input int e);
    hit_t h;
    if (hit_valid) begin
      if (expQ.size() == 0) begin
        expectEq("unexpected hit edge", e, -1);
      end else begin
        h = expQ.pop_front();
        expectEq("hit edge", e, h.edgeIdx);
        expectEq("hit center", int'(hit_center), h.center);
        expectEq("hit span", int'(hit_span), h.span);
      end
    end
    if (hit_valid8) hits8++;
    if (scan_done && doneEdge < 0) doneEdge = e;
  endtask

  task automatic runScan(input int pokeEdge);
    for (int e = 0; e < 600; e++) begin
      @(posedge clk_in);
      #1;
      if (e == 0 || e == pokeEdge + 1) data_valid = 1'b0;
      if (e == 0) expectEq("busy after start", int'(busy), 1);
      checkOutput(e);
      if (e == pokeEdge) begin
        clean_pattern = '0;
        data_valid    = 1'b1;
      end
      if (doneEdge >= 0) break;
    end
  endtask

  task automatic finishRow(input string nm, input int nHits, input int n8);
    expectEq({nm, " scan_done edge"}, doneEdge, W + 1);
    expectEq({nm, " missed hits"}, expQ.size(), 0);
    expQ.delete();
    expectEq({nm, " min8 hits"}, hits8, n8);
    expectEq({nm, " busy at done"}, int'(busy), 0);
`ifdef FINDER_HIT_COUNT_EN
    expectEq({nm, " hit_count"}, int'(hit_count), nHits);
`endif
    @(posedge clk_in);
    #1;
    expectEq({nm, " scan_done width"}, int'(scan_done), 0);
    expectEq({nm, " trailing hit"}, int'(hit_valid), 0);
  endtask

  task automatic expectIdle(input string nm);
    expectEq({nm, " hit_valid"}, int'(hit_valid), 0);
    expectEq({nm, " hit_center"}, int'(hit_center), 0);
    expectEq({nm, " hit_span"}, int'(hit_span), 0);
    expectEq({nm, " scan_done"}, int'(scan_done), 0);
    expectEq({nm, " busy"}, int'(busy), 0);
`ifdef FINDER_HIT_COUNT_EN
    expectEq({nm, " hit_count"}, int'(hit_count), 0);
`endif
  endtask

  initial begin
    logic [W-1:0] ones, finderRow, flushRow, scaledRow, bothRow;
    int vHits, vDone, vBusy;

    ones      = '1;
    finderRow = darkAt(darkAt(darkAt(ones, 10, 13), 18, 29), 34, 37);
    flushRow  = darkAt(darkAt(darkAt(ones, 452, 455), 460, 471), 476, 479);
    scaledRow = darkAt(darkAt(darkAt(ones, 100, 100), 102, 104), 106, 106);
    bothRow   = darkAt(darkAt(darkAt(finderRow, 452, 455), 460, 471), 476, 479);

    vecs[0] = mkVec("finder",  finderRow, 1, 39, 24, 28, 0, 0, 0, 1);
    vecs[1] = mkVec("ratio reject", darkAt(darkAt(darkAt(ones, 10, 13), 18, 23), 28, 31),
                    0, 0, 0, 0, 0, 0, 0, 0);
    vecs[2] = mkVec("row-end flush", flushRow, 1, 481, 466, 28, 0, 0, 0, 1);
    vecs[3] = mkVec("all zero", '0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4] = mkVec("all one", ones, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5] = mkVec("scaled T=7", scaledRow, 1, 108, 103, 7, 0, 0, 0, 0);
    vecs[6] = mkVec("two groups", bothRow, 2, 39, 24, 28, 481, 466, 28, 2);

    rst_in        = 1'b1;
    data_valid    = 1'b0;
    clean_pattern = '1;
    repeat (3) @(posedge clk_in);
    #1;
    expectIdle("reset");
    rst_in = 1'b0;

    for (int i = 0; i < NV; i++) begin
      $display("[TB] row %s", vecs[i].name);
      applyStimulus(vecs[i].row, vecs[i].nHits, vecs[i].e0, vecs[i].c0, vecs[i].s0,
                    vecs[i].e1, vecs[i].c1, vecs[i].s1);
      runScan(-5);
      finishRow(vecs[i].name, vecs[i].nHits, vecs[i].n8);
    end

    // Reset at edge 200 of a row whose second hit would land in FLUSH.
    $display("[TB] reset mid-scan");
    applyStimulus(bothRow, 1, 39, 24, 28, 0, 0, 0);
    for (int e = 0; e < 200; e++) begin
      @(posedge clk_in);
      #1;
      if (e == 0) data_valid = 1'b0;
      checkOutput(e);
    end
    expectEq("abort first hit seen", expQ.size(), 0);
    expQ.delete();
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;
    expectIdle("abort");
    rst_in = 1'b0;
    vHits = 0;
    vDone = 0;
    for (int e = 0; e < 400; e++) begin
      @(posedge clk_in);
      #1;
      if (hit_valid) vHits++;
      if (scan_done) vDone++;
    end
    expectEq("abort later hits", vHits, 0);
    expectEq("abort later scan_done", vDone, 0);

    $display("[TB] restart after reset");
    applyStimulus(vecs[0].row, 1, 39, 24, 28, 0, 0, 0);
    runScan(-5);
    finishRow("restart", 1, 1);

    // A start pulse with an all-dark row mid-scan must not disturb the latched row.
    $display("[TB] data_valid while busy");
    applyStimulus(scaledRow, 1, 108, 103, 7, 0, 0, 0);
    runScan(50);
    finishRow("busy poke", 1, 0);
    vBusy = 0;
    for (int e = 0; e < 5; e++) begin
      @(posedge clk_in);
      #1;
      if (busy) vBusy++;
    end
    expectEq("busy poke no restart", vBusy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
